// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Word-wide RAM stage with wait-state sequencer, done handshake
//            and an idle-only program-load write port.
// Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int ADDR        = 8,
    parameter int OP          = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [ADDR-1:0]      address,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic [OP+ADDR-1:0]   mem_bus_in,
    output logic [OP+ADDR-1:0]   mem_bus_out,
    output logic                 mem_oe,
    output logic                 mem_ready,
    output logic                 busy,
    output logic                 err,
    input  logic                 prog_en,
    input  logic                 prog_we,
    input  logic [ADDR-1:0]      prog_addr,
    input  logic [OP+ADDR-1:0]   prog_data
);

    localparam int              c_WORD_W    = OP + ADDR;
    localparam int              c_DEPTH     = 2 ** ADDR;
    localparam logic [2:0]      c_WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [ADDR-1:0]        addr_q, addr_d;
    logic [c_WORD_W-1:0]    data_q, data_d;
    logic                   is_wr_q, is_wr_d;
    logic [c_WORD_W-1:0]    bus_out_q, bus_out_d;
    logic                   oe_q, oe_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic [c_WORD_W-1:0]    mem_q [c_DEPTH];
    logic                   mem_we;
    logic [ADDR-1:0]        mem_waddr;
    logic [c_WORD_W-1:0]    mem_wdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        is_wr_d   = is_wr_q;
        bus_out_d = bus_out_q;
        oe_d      = 1'b0;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = data_q;

        case (state_q)
            S_IDLE: begin
                // Program-load owns the array only while the sequencer is idle
                if (prog_en) begin
                    if (prog_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = prog_addr;
                        mem_wdata = prog_data;
                    end
                end else if (mem_rd && mem_wr) begin
                    err_d = 1'b1;
                end else if (mem_rd || mem_wr) begin
                    addr_d  = address;
                    data_d  = mem_bus_in;
                    is_wr_d = mem_wr;
                    cnt_d   = c_WAIT_INIT;
                    state_d = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                ready_d = 1'b1;
                if (is_wr_q) begin
                    mem_we = 1'b1;
                end else begin
                    oe_d      = 1'b1;
                    bus_out_d = mem_q[addr_q];
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            data_q    <= '0;
            is_wr_q   <= 1'b0;
            bus_out_q <= '0;
            oe_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            is_wr_q   <= is_wr_d;
            bus_out_q <= bus_out_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // Storage is deliberately unreset; a reset before XFER leaves it untouched
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign mem_bus_out = bus_out_q;
    assign mem_oe      = oe_q;
    assign mem_ready   = ready_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Scoreboard bench for mem_stage with 2 and 0 wait-state instances.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;

    localparam int W_A = 2;
    localparam int W_B = 0;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  address_a = '0, paddr_a = '0;
    logic        rd_a = 1'b0, wr_a = 1'b0, pen_a = 1'b0, pwe_a = 1'b0;
    logic [15:0] bus_in_a = '0, pdata_a = '0;
    logic [15:0] bus_out_a;
    logic        oe_a, ready_a, busy_a, err_a;

    logic [7:0]  address_b = '0, paddr_b = '0;
    logic        rd_b = 1'b0, wr_b = 1'b0, pen_b = 1'b0, pwe_b = 1'b0;
    logic [15:0] bus_in_b = '0, pdata_b = '0;
    logic [15:0] bus_out_b;
    logic        oe_b, ready_b, busy_b, err_b;

    mem_stage #(.ADDR(8), .OP(8), .WAIT_STATES(W_A)) u_dut_a (
        .clk(clk), .nrst(nrst), .address(address_a), .mem_rd(rd_a), .mem_wr(wr_a),
        .mem_bus_in(bus_in_a), .mem_bus_out(bus_out_a), .mem_oe(oe_a),
        .mem_ready(ready_a), .busy(busy_a), .err(err_a), .prog_en(pen_a),
        .prog_we(pwe_a), .prog_addr(paddr_a), .prog_data(pdata_a)
    );

    mem_stage #(.ADDR(8), .OP(8), .WAIT_STATES(W_B)) u_dut_b (
        .clk(clk), .nrst(nrst), .address(address_b), .mem_rd(rd_b), .mem_wr(wr_b),
        .mem_bus_in(bus_in_b), .mem_bus_out(bus_out_b), .mem_oe(oe_b),
        .mem_ready(ready_b), .busy(busy_b), .err(err_b), .prog_en(pen_b),
        .prog_we(pwe_b), .prog_addr(paddr_b), .prog_data(pdata_b)
    );

    typedef struct {
        logic        rd;
        logic [15:0] data;
        int          req_cyc;
    } exp_t;

    exp_t        sb_a[$];
    exp_t        sb_b[$];
    exp_t        ea, eb;
    logic [15:0] model [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          rdy_a  = 0;
    int          rdy_b  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ready_a === 1'b1) begin
            rdy_a++;
            if (sb_a.size() == 0) begin
                check_eq("a_spurious_ready", 32'(ready_a), 32'd0);
            end else begin
                ea = sb_a.pop_front();
                check_eq("a_latency", 32'(cyc - ea.req_cyc), 32'(W_A + 2));
                check_eq("a_oe", 32'(oe_a), 32'(ea.rd));
                if (ea.rd) check_eq("a_rdata", 32'(bus_out_a), 32'(ea.data));
            end
        end else if (nrst && oe_a !== 1'b0) begin
            check_eq("a_oe_stray", 32'(oe_a), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (ready_b === 1'b1) begin
            rdy_b++;
            if (sb_b.size() == 0) begin
                check_eq("b_spurious_ready", 32'(ready_b), 32'd0);
            end else begin
                eb = sb_b.pop_front();
                check_eq("b_latency", 32'(cyc - eb.req_cyc), 32'(W_B + 2));
                check_eq("b_oe", 32'(oe_b), 32'(eb.rd));
                if (eb.rd) check_eq("b_rdata", 32'(bus_out_b), 32'(eb.data));
            end
        end
    end

    task automatic req_a(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        rd_a = rd; wr_a = wr; address_a = a; bus_in_a = d;
        e.rd = rd; e.data = rd ? model[a] : 16'h0; e.req_cyc = cyc;
        sb_a.push_back(e);
        if (wr) model[a] = d;
        @(negedge clk);
        rd_a = 1'b0; wr_a = 1'b0;
        address_a = 8'($urandom);
        bus_in_a  = 16'($urandom);
        check_eq("a_busy_after_req", 32'(busy_a), 32'd1);
    endtask

    task automatic wait_a();
        for (int n = 0; n < 30 && (sb_a.size() != 0 || busy_a); n++) @(negedge clk);
        check_eq("a_drain", 32'(sb_a.size()), 32'd0);
    endtask

    initial begin
        int   start;
        exp_t e;

        #1 nrst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_bus_out", 32'(bus_out_a), 32'd0);
        check_eq("rst_oe",      32'(oe_a),      32'd0);
        check_eq("rst_ready",   32'(ready_a),   32'd0);
        check_eq("rst_busy",    32'(busy_a),    32'd0);
        check_eq("rst_err",     32'(err_a),     32'd0);
        check_eq("rst_b_busy",  32'(busy_b),    32'd0);
        nrst = 1'b1;

        // Write then read back with two wait states
        req_a(1'b0, 1'b1, 8'h3C, 16'hA55A);
        wait_a();
        req_a(1'b1, 1'b0, 8'h3C, 16'h0000);
        wait_a();

        // Illegal simultaneous read and write
        @(negedge clk);
        rd_a = 1'b1; wr_a = 1'b1; address_a = 8'h3C; bus_in_a = 16'h0BAD;
        @(negedge clk);
        rd_a = 1'b0; wr_a = 1'b0;
        check_eq("err_pulse", 32'(err_a),  32'd1);
        check_eq("err_busy",  32'(busy_a), 32'd0);
        @(negedge clk);
        check_eq("err_clear", 32'(err_a),  32'd0);
        check_eq("err_idle",  32'(busy_a), 32'd0);
        req_a(1'b1, 1'b0, 8'h3C, 16'h0000);
        wait_a();

        // Program-load with a read request that must be ignored
        @(negedge clk);
        pen_a = 1'b1; rd_a = 1'b1; address_a = 8'h3C;
        @(negedge clk);
        check_eq("prog_busy0", 32'(busy_a), 32'd0);
        check_eq("prog_err0",  32'(err_a),  32'd0);
        pwe_a = 1'b1; paddr_a = 8'h10; pdata_a = 16'h1234;
        model[8'h10] = 16'h1234;
        @(negedge clk);
        check_eq("prog_busy1", 32'(busy_a), 32'd0);
        pen_a = 1'b0; pwe_a = 1'b0; address_a = 8'h10; rd_a = 1'b1;
        e.rd = 1'b1; e.data = 16'h1234; e.req_cyc = cyc;
        sb_a.push_back(e);
        @(negedge clk);
        rd_a = 1'b0;
        check_eq("prog_rd_busy", 32'(busy_a), 32'd1);
        wait_a();

        // Reset while a write is waiting discards it
        req_a(1'b0, 1'b1, 8'h20, 16'h0BEE);
        wait_a();
        @(negedge clk);
        wr_a = 1'b1; address_a = 8'h20; bus_in_a = 16'hFFFF;
        @(negedge clk);
        wr_a = 1'b0;
        check_eq("rstw_busy", 32'(busy_a), 32'd1);
        nrst = 1'b0;
        #1;
        check_eq("rstw_bus_out", 32'(bus_out_a), 32'd0);
        check_eq("rstw_oe",      32'(oe_a),      32'd0);
        check_eq("rstw_ready",   32'(ready_a),   32'd0);
        check_eq("rstw_busy0",   32'(busy_a),    32'd0);
        check_eq("rstw_err",     32'(err_a),     32'd0);
        @(negedge clk);
        nrst = 1'b1;
        req_a(1'b1, 1'b0, 8'h20, 16'h0000);
        wait_a();

        // Second read while busy is ignored
        start = rdy_a;
        @(negedge clk);
        rd_a = 1'b1; address_a = 8'h3C;
        e.rd = 1'b1; e.data = model[8'h3C]; e.req_cyc = cyc;
        sb_a.push_back(e);
        @(negedge clk);
        address_a = 8'h10;
        @(negedge clk);
        @(negedge clk);
        rd_a = 1'b0;
        wait_a();
        repeat (6) @(negedge clk);
        check_eq("busy_ignore_cnt", 32'(rdy_a - start), 32'd1);

        // Zero wait states: back-to-back held reads
        @(negedge clk);
        pen_b = 1'b1; pwe_b = 1'b1; paddr_b = 8'h00; pdata_b = 16'h1111;
        @(negedge clk);
        paddr_b = 8'hFF; pdata_b = 16'h2222;
        @(negedge clk);
        pen_b = 1'b0; pwe_b = 1'b0;
        rd_b = 1'b1; address_b = 8'h00;
        e.rd = 1'b1; e.data = 16'h1111; e.req_cyc = cyc;
        sb_b.push_back(e);
        @(negedge clk);
        check_eq("b_busy_t0", 32'(busy_b), 32'd1);
        address_b = 8'hFF;
        @(negedge clk);
        check_eq("b_busy_t1", 32'(busy_b), 32'd0);
        e.rd = 1'b1; e.data = 16'h2222; e.req_cyc = cyc;
        sb_b.push_back(e);
        @(negedge clk);
        check_eq("b_busy_t2", 32'(busy_b), 32'd1);
        rd_b = 1'b0;
        @(negedge clk);
        check_eq("b_busy_t3", 32'(busy_b), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("b_drain", 32'(sb_b.size()), 32'd0);
        check_eq("b_ready_cnt", 32'(rdy_b), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
